// File: rtl/shift_reg_loader.sv
// shift_reg_loader
//   Feeds a serial-in/parallel-out shift_reg. Parallel words arrive on a
//   valid/ready handshake into a one-entry holding register, are moved into an
//   active shift register and sent one bit per clk on d/en/dir. After MSB
//   enabled cycles the downstream shift_reg holds the word exactly.
//
// Parameters
//   MSB  word width (must match downstream shift_reg)
//   GAP  idle (en=0) cycles between consecutive words, 0 = back-to-back
//
// Ports
//   clk, rst          clock, async active-high reset
//   in_data, in_dir   word and its shift direction (0 = MSB-first, 1 = LSB-first)
//   in_valid/in_ready handshake; accept when both high at posedge
//   d, en, dir        serial bit, shift enable, direction to shift_reg
//   busy              word in flight or holding register occupied
//   done              one-cycle pulse after the last bit of a word is shifted
module shift_reg_loader #(
  parameter int MSB = 16,
  parameter int GAP = 1
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [MSB-1:0] in_data,
  input  logic           in_dir,
  input  logic           in_valid,
  output logic           in_ready,
  output logic           d,
  output logic           en,
  output logic           dir,
  output logic           busy,
  output logic           done
);

  localparam int CW = (MSB > 1) ? $clog2(MSB) : 1;
  localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;
  localparam logic [CW-1:0] CLAST = CW'(MSB - 1);
  localparam logic [GW-1:0] GLAST = GW'((GAP > 0) ? GAP - 1 : 0);

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_GAP} state_t;

  typedef struct packed {
    logic [MSB-1:0] word;
    logic           dir;
    logic           full;
  } hold_t;

  state_t         state_q, state_nxt;
  hold_t          hold_q;
  logic [MSB-1:0] act_q;
  logic           act_dir_q;
  logic [CW-1:0]  cnt_q;
  logic [GW-1:0]  gcnt_q;
  logic           done_q;

  logic load;    // move holding -> active this edge
  logic accept;
  logic last;

  assign last   = (cnt_q == CLAST);
  assign accept = in_valid && in_ready;

  // next-state / transfer decision
  always_comb begin
    state_nxt = state_q;
    load      = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (hold_q.full) begin
          load      = 1'b1;
          state_nxt = S_SHIFT;
        end
      end
      S_SHIFT: begin
        if (last) begin
          if (GAP > 0) begin
            state_nxt = S_GAP;
          end else if (hold_q.full) begin
            load      = 1'b1;        // back-to-back: en stays high
          end else begin
            state_nxt = S_IDLE;
          end
        end
      end
      S_GAP: begin
        // The last gap cycle does IDLE's transfer itself so the en=0 window
        // between queued words is exactly GAP cycles, not GAP+1.
        if (gcnt_q == GLAST) begin
          if (hold_q.full) begin
            load      = 1'b1;
            state_nxt = S_SHIFT;
          end else begin
            state_nxt = S_IDLE;
          end
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_nxt;
  end

  // holding register; in_ready is low whenever full, so accept and load
  // never hit the same edge
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_q <= '0;
    end else if (load) begin
      hold_q.full <= 1'b0;
    end else if (accept) begin
      hold_q <= '{word: in_data, dir: in_dir, full: 1'b1};
    end
  end

  // active shift register; shifts toward the bit just sent
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      act_q     <= '0;
      act_dir_q <= 1'b0;
      cnt_q     <= '0;
    end else if (load) begin
      act_q     <= hold_q.word;
      act_dir_q <= hold_q.dir;
      cnt_q     <= '0;
    end else if (state_q == S_SHIFT) begin
      act_q <= act_dir_q ? (act_q >> 1) : (act_q << 1);
      cnt_q <= last ? '0 : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                      gcnt_q <= '0;
    else if (state_q == S_GAP && gcnt_q != GLAST) gcnt_q <= gcnt_q + 1'b1;
    else                                          gcnt_q <= '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) done_q <= 1'b0;
    else     done_q <= (state_q == S_SHIFT) && last;
  end

  assign en       = (state_q == S_SHIFT);
  assign d        = en && (act_dir_q ? act_q[0] : act_q[MSB-1]);
  assign dir      = act_dir_q;
  assign done     = done_q;
  assign busy     = (state_q != S_IDLE) || hold_q.full;
  assign in_ready = !hold_q.full && !rst;

endmodule

// File: tb/tb_shift_reg_loader.sv
// Directed bench for shift_reg_loader. Two instances share clk/rst:
// u_a (GAP=0) carries most scenarios, u_b (GAP=2) the inter-word gap case.
// A downstream shift_reg is modelled per instance and snapshotted on done.
module tb_shift_reg_loader;
  localparam int W = 16;

  logic clk = 1'b0;
  logic rst;
  logic [W-1:0] in_data_a, in_data_b;
  logic in_dir_a, in_dir_b, in_valid_a, in_valid_b;
  logic in_ready_a, d_a, en_a, dir_a, busy_a, done_a;
  logic in_ready_b, d_b, en_b, dir_b, busy_b, done_b;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  shift_reg_loader #(.MSB(W), .GAP(0)) u_a (
    .clk(clk), .rst(rst), .in_data(in_data_a), .in_dir(in_dir_a),
    .in_valid(in_valid_a), .in_ready(in_ready_a), .d(d_a), .en(en_a),
    .dir(dir_a), .busy(busy_a), .done(done_a));

  shift_reg_loader #(.MSB(W), .GAP(2)) u_b (
    .clk(clk), .rst(rst), .in_data(in_data_b), .in_dir(in_dir_b),
    .in_valid(in_valid_b), .in_ready(in_ready_b), .d(d_b), .en(en_b),
    .dir(dir_b), .busy(busy_b), .done(done_b));

  // downstream shift_reg models + logs, sampled mid-cycle
  logic         bits_a[$];
  logic         en_log_a[$];
  logic [W-1:0] snap_a[$];
  logic [W-1:0] sr_a;
  int           dir1_a = 0;
  logic         en_log_b[$];
  logic [W-1:0] snap_b[$];
  logic [W-1:0] sr_b;

  always @(negedge clk) begin
    if (rst) sr_a <= '0;
    else begin
      if (done_a) snap_a.push_back(sr_a);
      en_log_a.push_back(en_a);
      if (en_a) begin
        bits_a.push_back(d_a);
        sr_a <= dir_a ? {d_a, sr_a[W-1:1]} : {sr_a[W-2:0], d_a};
        if (dir_a) dir1_a <= dir1_a + 1;
      end
    end
  end

  always @(negedge clk) begin
    if (rst) sr_b <= '0;
    else begin
      if (done_b) snap_b.push_back(sr_b);
      en_log_b.push_back(en_b);
      if (en_b) sr_b <= dir_b ? {d_b, sr_b[W-1:1]} : {sr_b[W-2:0], d_b};
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // call mid-cycle; returns mid-cycle after the accepting edge
  task automatic send(input bit to_b, input logic [W-1:0] w, input logic dr, output int waited);
    waited = 0;
    if (to_b) begin in_data_b = w; in_dir_b = dr; in_valid_b = 1'b1; end
    else      begin in_data_a = w; in_dir_a = dr; in_valid_a = 1'b1; end
    while (!(to_b ? in_ready_b : in_ready_a) && waited < 200) begin
      @(negedge clk); #1; waited++;
    end
    if (waited >= 200) chk("send_timeout", 32'd0, 32'd1);
    @(negedge clk); #1;
    in_valid_a = 1'b0;
    in_valid_b = 1'b0;
  endtask

  task automatic wait_snaps(input bit to_b, input int n);
    int t = 0;
    while ((to_b ? snap_b.size() : snap_a.size()) < n && t < 300) begin
      @(negedge clk); #1; t++;
    end
    if (t >= 300) chk("done_timeout", 32'd0, 32'd1);
    repeat (2) begin @(negedge clk); #1; end
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(negedge clk); #1; end
  endtask

  // bits in transmit order, first bit ends up in the MSB
  function automatic logic [W-1:0] stream_a(input int base);
    logic [W-1:0] v = '0;
    for (int i = 0; i < W; i++) v = {v[W-2:0], bits_a[base+i]};
    return v;
  endfunction

  function automatic int ones(input logic q[$], input int base);
    int n = 0;
    for (int i = base; i < q.size(); i++) if (q[i]) n++;
    return n;
  endfunction

  function automatic int max_run(input logic q[$], input int base);
    int best = 0;
    int cur = 0;
    for (int i = base; i < q.size(); i++) begin
      cur = q[i] ? cur + 1 : 0;
      if (cur > best) best = cur;
    end
    return best;
  endfunction

  // zeros between the first and second run of ones
  function automatic int gap_len(input logic q[$], input int base);
    int i = base;
    int g = 0;
    while (i < q.size() && !q[i]) i++;
    while (i < q.size() && q[i]) i++;
    while (i < q.size() && !q[i]) begin g++; i++; end
    if (i >= q.size()) g = -1;
    return g;
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int w, lat, bb, bs, be, bd;
    rst = 1'b1;
    in_data_a = '0; in_dir_a = 1'b0; in_valid_a = 1'b0;
    in_data_b = '0; in_dir_b = 1'b0; in_valid_b = 1'b0;
    idle(2);

    // 1: reset state
    chk("rst_en", en_a, 0);
    chk("rst_d", d_a, 0);
    chk("rst_dir", dir_a, 0);
    chk("rst_done", done_a, 0);
    chk("rst_busy", busy_a, 0);
    chk("rst_in_ready", in_ready_a, 0);
    rst = 1'b0;
    idle(1);
    chk("rel_in_ready", in_ready_a, 1);
    chk("rel_busy", busy_a, 0);

    // 2: A5C3 MSB-first
    bb = bits_a.size(); bs = snap_a.size(); be = en_log_a.size();
    send(0, 16'hA5C3, 1'b0, w);
    lat = 0;
    while (!done_a && lat < 100) begin @(negedge clk); #1; lat++; end
    chk("t2_done_latency", lat, 17);
    idle(3);
    chk("t2_stream", stream_a(bb), 16'hA5C3);
    chk("t2_shreg", snap_a[bs], 16'hA5C3);
    chk("t2_en_cycles", ones(en_log_a, be), 16);
    chk("t2_done_cnt", snap_a.size() - bs, 1);

    // 3: 0001 LSB-first
    bb = bits_a.size(); bs = snap_a.size(); bd = dir1_a;
    send(0, 16'h0001, 1'b1, w);
    wait_snaps(0, bs + 1);
    chk("t3_stream", stream_a(bb), 16'h8000);
    chk("t3_shreg", snap_a[bs], 16'h0001);
    chk("t3_dir1_cycles", dir1_a - bd, 16);
    chk("t3_dir_held", dir_a, 1);

    // 4a: GAP=0, two queued words run contiguously
    bs = snap_a.size(); be = en_log_a.size();
    send(0, 16'h00FF, 1'b0, w);
    send(0, 16'h8001, 1'b1, w);
    wait_snaps(0, bs + 2);
    chk("t4a_en_total", ones(en_log_a, be), 32);
    chk("t4a_en_run", max_run(en_log_a, be), 32);
    chk("t4a_shreg0", snap_a[bs], 16'h00FF);
    chk("t4a_shreg1", snap_a[bs+1], 16'h8001);

    // 4b: GAP=2 instance
    bs = snap_b.size(); be = en_log_b.size();
    send(1, 16'hC33C, 1'b0, w);
    send(1, 16'h0F0F, 1'b1, w);
    wait_snaps(1, bs + 2);
    chk("t4b_gap", gap_len(en_log_b, be), 2);
    chk("t4b_en_run", max_run(en_log_b, be), 16);
    chk("t4b_shreg0", snap_b[bs], 16'hC33C);
    chk("t4b_shreg1", snap_b[bs+1], 16'h0F0F);

    // 5: three words back-to-back, third stalls while holding is full
    bs = snap_a.size(); be = en_log_a.size();
    send(0, 16'h1357, 1'b0, w);
    send(0, 16'h2468, 1'b1, w);
    chk("t5_busy_full", {in_ready_a, busy_a}, 2'b01);
    send(0, 16'hBEEF, 1'b0, w);
    chk("t5_third_wait", w, 15);
    wait_snaps(0, bs + 3);
    chk("t5_en_run", max_run(en_log_a, be), 48);
    chk("t5_shreg0", snap_a[bs], 16'h1357);
    chk("t5_shreg1", snap_a[bs+1], 16'h2468);
    chk("t5_shreg2", snap_a[bs+2], 16'hBEEF);

    // 6: reset at bit 7 of FFFF, then 1234
    bs = snap_a.size();
    send(0, 16'hFFFF, 1'b0, w);
    repeat (8) @(posedge clk);
    #2;
    chk("t6_en_before", en_a, 1);
    rst = 1'b1;
    #1;
    chk("t6_en_rst", en_a, 0);
    chk("t6_d_rst", d_a, 0);
    chk("t6_busy_rst", busy_a, 0);
    idle(2);
    rst = 1'b0;
    idle(1);
    bb = bits_a.size();
    send(0, 16'h1234, 1'b0, w);
    wait_snaps(0, bs + 1);
    idle(2);
    chk("t6_done_cnt", snap_a.size() - bs, 1);
    chk("t6_shreg", snap_a[bs], 16'h1234);
    chk("t6_stream", stream_a(bb), 16'h1234);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
